// File: rtl/host_descriptor_arbiter_mc.sv
// host_descriptor_arbiter_mc
// Collects {tsntag, bufid} descriptors from CH_NUM sources. Each source has its
// own FIFO. A three-state arbiter (IDLE -> LOAD -> OUT) forwards one descriptor
// at a time to frame inverse mapping. Arbitration is round-robin or strict
// priority, selected at run time.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   iv_tsntag, iv_bufid   per-channel descriptor fields, channel c at slice c
//   iv_descriptor_wr      per-channel write strobe
//   ov_descriptor_ack     per-channel ack, one cycle after each strobe
//   ov_discard_pulse      per-channel drop flag, one cycle after a strobe to a full FIFO
//   ov_fifo_usedw         per-channel occupancy (FIFO_AW+1 bits each)
//   i_arb_mode            0 = round-robin, 1 = strict priority (ch0 highest)
//   i_descriptor_ready    downstream can take a descriptor (sampled in IDLE)
//   ov_descriptor         forwarded {tsntag, bufid}
//   ov_src_ch             source channel of ov_descriptor
//   o_descriptor_wr       one-cycle output strobe
//   arb_state             FSM state for debug (IDLE=0, LOAD=1, OUT=2)
module host_descriptor_arbiter_mc #(
    parameter int CH_NUM     = 2,
    parameter int CH_ID_W    = 1,
    parameter int TAG_W      = 48,
    parameter int BUFID_W    = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [CH_NUM*TAG_W-1:0]            iv_tsntag,
    input  logic [CH_NUM*BUFID_W-1:0]          iv_bufid,
    input  logic [CH_NUM-1:0]                  iv_descriptor_wr,
    output logic [CH_NUM-1:0]                  ov_descriptor_ack,
    input  logic                               i_arb_mode,
    output logic [TAG_W+BUFID_W-1:0]           ov_descriptor,
    output logic [CH_ID_W-1:0]                 ov_src_ch,
    output logic                               o_descriptor_wr,
    input  logic                               i_descriptor_ready,
    output logic [CH_NUM-1:0]                  ov_discard_pulse,
    output logic [CH_NUM*(FIFO_AW+1)-1:0]      ov_fifo_usedw,
    output logic [1:0]                         arb_state
);

    localparam int DESC_W = TAG_W + BUFID_W;
    localparam int UW     = FIFO_AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CH_ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_ID_W-1:0]    src_ch_q, src_ch_d;
    logic [DESC_W-1:0]     desc_q, desc_d;
    logic                  desc_wr_q, desc_wr_d;
    logic [CH_NUM-1:0]     ack_q, ack_d;
    logic [CH_NUM-1:0]     discard_q, discard_d;
    logic [UW-1:0]         usedw_q [CH_NUM];
    logic [UW-1:0]         usedw_d [CH_NUM];
    logic [FIFO_AW-1:0]    wr_ptr_q [CH_NUM];
    logic [FIFO_AW-1:0]    wr_ptr_d [CH_NUM];
    logic [FIFO_AW-1:0]    rd_ptr_q [CH_NUM];
    logic [FIFO_AW-1:0]    rd_ptr_d [CH_NUM];
    logic [DESC_W-1:0]     mem_q [CH_NUM][FIFO_DEPTH];

    logic [CH_NUM-1:0]     nonempty;
    logic [CH_NUM-1:0]     wr_ok;
    logic [CH_NUM-1:0]     pop;
    logic                  any_req;
    logic [CH_ID_W-1:0]    rr_grant, strict_grant, grant;
    logic [DESC_W-1:0]     popped_head;

    // Grant selection. Round-robin prefers the lowest non-empty channel above
    // the pointer, and otherwise wraps to the lowest non-empty channel at or
    // below it. Descending loops let the lowest index win.
    always_comb begin
        logic              found_hi;
        logic [CH_ID_W-1:0] g_hi, g_lo;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        found_hi     = 1'b0;
        g_hi         = '0;
        g_lo         = '0;
        strict_grant = '0;
        for (int c = CH_NUM - 1; c >= 0; c--) begin
            nonempty[c] = (usedw_q[c] != '0);
            if (nonempty[c]) begin
                strict_grant = CH_ID_W'(c);
                if (CH_ID_W'(c) > rr_ptr_q) begin
                    found_hi = 1'b1;
                    g_hi     = CH_ID_W'(c);
                end else begin
                    g_lo = CH_ID_W'(c);
                end
            end
        end
        any_req  = |nonempty;
        rr_grant = found_hi ? g_hi : g_lo;
        grant    = i_arb_mode ? strict_grant : rr_grant;
    end

    // The head was popped at the IDLE edge, so in LOAD it sits one slot
    // behind the channel's read pointer.
    assign popped_head = mem_q[src_ch_q][rd_ptr_q[src_ch_q] - FIFO_AW'(1)];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        src_ch_d  = src_ch_q;
        desc_d    = desc_q;
        desc_wr_d = 1'b0;
        pop       = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_descriptor_ready && any_req) begin
                    pop      = CH_NUM'(1) << grant;
                    src_ch_d = grant;
                    rr_ptr_d = grant;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                desc_d    = popped_head;
                desc_wr_d = 1'b1;
                state_d   = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Full is judged on start-of-cycle occupancy, so a same-cycle pop
        // does not make room for a write.
        for (int c = 0; c < CH_NUM; c++) begin
            wr_ok[c]    = iv_descriptor_wr[c] && (usedw_q[c] != UW'(FIFO_DEPTH));
            wr_ptr_d[c] = wr_ptr_q[c] + FIFO_AW'(wr_ok[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + FIFO_AW'(pop[c]);
            usedw_d[c]  = usedw_q[c] + UW'(wr_ok[c]) - UW'(pop[c]);
        end
        ack_d     = iv_descriptor_wr;
        discard_d = iv_descriptor_wr & ~wr_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= CH_ID_W'(CH_NUM - 1);
            src_ch_q  <= '0;
            desc_q    <= '0;
            desc_wr_q <= 1'b0;
            ack_q     <= '0;
            discard_q <= '0;
            usedw_q   <= '{default: '0};
            wr_ptr_q  <= '{default: '0};
            rd_ptr_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            src_ch_q  <= src_ch_d;
            desc_q    <= desc_d;
            desc_wr_q <= desc_wr_d;
            ack_q     <= ack_d;
            discard_q <= discard_d;
            usedw_q   <= usedw_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // NOTE: FIFO storage has no reset; only entries covered by usedw are ever read.
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < CH_NUM; c++) begin
            if (wr_ok[c]) begin
                mem_q[c][wr_ptr_q[c]] <= {iv_tsntag[c*TAG_W +: TAG_W], iv_bufid[c*BUFID_W +: BUFID_W]};
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            ov_fifo_usedw[c*UW +: UW] = usedw_q[c];
        end
    end

    assign ov_descriptor_ack = ack_q;
    assign ov_discard_pulse  = discard_q;
    assign ov_descriptor     = desc_q;
    assign ov_src_ch         = src_ch_q;
    assign o_descriptor_wr   = desc_wr_q;
    assign arb_state         = state_q;

endmodule

// File: tb/tb_host_descriptor_arbiter_mc.sv
// Directed testbench for host_descriptor_arbiter_mc with 4 channels and
// 16-entry FIFOs.
module tb_host_descriptor_arbiter_mc;

    localparam int CH  = 4;
    localparam int IDW = 2;
    localparam int TW  = 48;
    localparam int BW  = 9;
    localparam int DEP = 16;
    localparam int AW  = 4;
    localparam int UW  = AW + 1;
    localparam int DW  = TW + BW;

    logic               clk = 1'b0;
    logic               rst;
    logic [CH*TW-1:0]   tsntag;
    logic [CH*BW-1:0]   bufid;
    logic [CH-1:0]      wr;
    logic [CH-1:0]      ack;
    logic               arb_mode;
    logic [DW-1:0]      desc;
    logic [IDW-1:0]     src_ch;
    logic               desc_wr;
    logic               ready;
    logic [CH-1:0]      discard;
    logic [CH*UW-1:0]   usedw;
    logic [1:0]         state;

    int n_tests = 0;
    int n_fail  = 0;

    host_descriptor_arbiter_mc #(
        .CH_NUM(CH), .CH_ID_W(IDW), .TAG_W(TW), .BUFID_W(BW),
        .FIFO_DEPTH(DEP), .FIFO_AW(AW)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .iv_tsntag(tsntag), .iv_bufid(bufid), .iv_descriptor_wr(wr),
        .ov_descriptor_ack(ack), .i_arb_mode(arb_mode),
        .ov_descriptor(desc), .ov_src_ch(src_ch), .o_descriptor_wr(desc_wr),
        .i_descriptor_ready(ready), .ov_discard_pulse(discard),
        .ov_fifo_usedw(usedw), .arb_state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] make_desc(input int c, input int k);
        logic [TW-1:0] t;
        logic [BW-1:0] b;
        t = {8'(c), 8'hC0, 32'(k + 1)};
        b = BW'(c * 32 + k);
        return {t, b};
    endfunction

    function automatic logic [UW-1:0] usedw_of(input int c);
        return usedw[c*UW +: UW];
    endfunction

    task automatic set_ch(input int c, input int k);
        logic [DW-1:0] d;
        d = make_desc(c, k);
        tsntag[c*TW +: TW] = d[DW-1:BW];
        bufid[c*BW +: BW]  = d[BW-1:0];
    endtask

    task automatic do_reset();
        rst = 1'b1; wr = '0; ready = 1'b0; arb_mode = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic preload2();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) set_ch(c, k);
            wr = '1;
            step();
        end
        wr = '0;
        for (int c = 0; c < CH; c++) check("preload_usedw", 64'(usedw_of(c)), 64'd2);
    endtask

    // Steps until o_descriptor_wr is seen or the budget runs out.
    task automatic wait_out(output bit seen, output int n);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            step();
            n++;
            if (desc_wr) seen = 1'b1;
        end
    endtask

    task automatic drain(input int exp_ch[8], input int switch_after);
        int cnt[CH];
        bit seen;
        int n;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_out(seen, n);
            check("out_seen", 64'(seen), 64'd1);
            if (!seen) break;
            if (i > 0) check("out_spacing", 64'(n), 64'd3);
            check("out_ch", 64'(src_ch), 64'(exp_ch[i]));
            check("out_desc", 64'(desc), 64'(make_desc(exp_ch[i], cnt[exp_ch[i]])));
            cnt[exp_ch[i]]++;
            if (i + 1 == switch_after) arb_mode = 1'b0;
        end
        ready = 1'b0;
        step();
        for (int c = 0; c < CH; c++) check("drain_usedw", 64'(usedw_of(c)), 64'd0);
    endtask

    initial begin
        int acks;
        int drops;
        int outs;
        logic [DW-1:0] last_desc;

        tsntag = '0; bufid = '0;
        do_reset();

        // 1: reset state, then single ch0 descriptor latency
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_desc", 64'(desc), 64'd0);
        check("rst_src", 64'(src_ch), 64'd0);
        check("rst_wr", 64'(desc_wr), 64'd0);
        check("rst_discard", 64'(discard), 64'd0);
        check("rst_usedw", 64'(usedw), 64'd0);
        check("rst_state", 64'(state), 64'd0);
        ready = 1'b1;
        tsntag[0 +: TW] = 48'h0000_1111_2222;
        bufid[0 +: BW]  = 9'd5;
        wr = 4'b0001;
        step();
        wr = '0;
        check("t1_ack", 64'(ack), 64'd1);
        check("t1_wr_t1", 64'(desc_wr), 64'd0);
        step();
        check("t1_state_load", 64'(state), 64'd1);
        step();
        check("t1_wr_t3", 64'(desc_wr), 64'd1);
        check("t1_desc", 64'(desc), 64'({48'h0000_1111_2222, 9'd5}));
        check("t1_src", 64'(src_ch), 64'd0);
        step();
        check("t1_wr_pulse", 64'(desc_wr), 64'd0);
        check("t1_desc_hold", 64'(desc), 64'({48'h0000_1111_2222, 9'd5}));

        // 2: round-robin
        do_reset();
        preload2();
        drain('{0, 1, 2, 3, 0, 1, 2, 3}, -1);

        // 3a: strict priority
        do_reset();
        arb_mode = 1'b1;
        preload2();
        drain('{0, 0, 1, 1, 2, 2, 3, 3}, -1);

        // 3b: strict, switching to round-robin after the 3rd output (pointer=1)
        do_reset();
        arb_mode = 1'b1;
        preload2();
        drain('{0, 0, 1, 2, 3, 1, 2, 3}, 3);

        // 4: overflow on ch1 with ready low
        do_reset();
        acks = 0;
        drops = 0;
        for (int k = 0; k < 18; k++) begin
            set_ch(1, k);
            wr = 4'b0010;
            step();
            if (ack[1]) acks++;
            if (discard[1]) drops++;
            if (k >= 16) check("ovf_discard_late", 64'(discard[1]), 64'd1);
        end
        wr = '0;
        check("ovf_acks", 64'(acks), 64'd18);
        check("ovf_drops", 64'(drops), 64'd2);
        check("ovf_usedw", 64'(usedw_of(1)), 64'd16);
        check("ovf_other_usedw", 64'(usedw_of(0)), 64'd0);
        // write to full FIFO in the same cycle as its pop
        ready = 1'b1;
        set_ch(1, 18);
        wr = 4'b0010;
        step();
        ready = 1'b0;
        wr = '0;
        check("popwr_ack", 64'(ack[1]), 64'd1);
        check("popwr_discard", 64'(discard[1]), 64'd1);
        check("popwr_usedw", 64'(usedw_of(1)), 64'd15);
        step();
        check("popwr_out", 64'(desc_wr), 64'd1);
        check("popwr_src", 64'(src_ch), 64'd1);
        check("popwr_desc", 64'(desc), 64'(make_desc(1, 0)));

        // 5: backpressure
        outs = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (desc_wr) outs++;
        end
        check("bp_no_out", 64'(outs), 64'd0);
        check("bp_state", 64'(state), 64'd0);
        check("bp_usedw", 64'(usedw_of(1)), 64'd15);
        ready = 1'b1;
        step();
        ready = 1'b0;
        last_desc = '0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (desc_wr) begin
                outs++;
                last_desc = desc;
            end
        end
        check("bp_one_out", 64'(outs), 64'd1);
        check("bp_desc", 64'(last_desc), 64'(make_desc(1, 1)));
        check("bp_usedw_after", 64'(usedw_of(1)), 64'd14);

        // 6: reset during LOAD
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("rl_in_load", 64'(state), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        outs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (desc_wr) outs++;
        end
        check("rl_no_out", 64'(outs), 64'd0);
        check("rl_usedw", 64'(usedw), 64'd0);
        check("rl_state", 64'(state), 64'd0);
        ready = 1'b1;
        set_ch(2, 0);
        wr = 4'b0100;
        step();
        wr = '0;
        step();
        step();
        check("rl_resume_wr", 64'(desc_wr), 64'd1);
        check("rl_resume_src", 64'(src_ch), 64'd2);
        check("rl_resume_desc", 64'(desc), 64'(make_desc(2, 0)));
        ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
